inst_axi_responder: RTL

- Slave end of the instruction-fetch SRAM-like bus: the fetch stage drives inst_req/inst_addr; this block answers with inst_addr_ok and later inst_rdata/inst_data_ok.
- Converts each accepted request into a single-beat AXI read (AR/R channels) toward the memory system.
- Supports up to DEPTH outstanding reads; returns data strictly in request order.
- Returns every accepted request exactly once; the fetch stage relies on this to drain cancelled fetches.

---
 rtl/inst_axi_responder.sv | 61 ++++++
 1 files changed

// File: rtl/inst_axi_responder.sv
// inst_axi_responder: SRAM-like instruction fetch slave bridged to single-beat in-order AXI reads
module inst_axi_responder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  output logic        inst_rerr,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arid,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  output logic        rready
);
  logic [CNT_W-1:0] count;
  logic             proto_err;
  assign arlen   = 8'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arid    = 4'd0;
  // accept only into a free AR slot with a credit left; responses pass straight through
  always_comb begin
    inst_addr_ok = resetn && inst_req && (!arvalid || arready) && (count < CNT_W'(DEPTH));
    inst_data_ok = rvalid && rready && (count != '0);
    inst_rerr    = inst_data_ok && (rresp != 2'b00);
    inst_rdata   = rready ? rdata : '0;
  end
  // AR slot, outstanding credit counter, R-ready and sticky protocol-error flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid   <= 1'b0;
      araddr    <= '0;
      count     <= '0;
      rready    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      rready <= 1'b1;
      if (inst_addr_ok) begin
        arvalid <= 1'b1;
        araddr  <= inst_addr;
      end else if (arready) begin
        arvalid <= 1'b0;
      end
      count <= count + CNT_W'(inst_addr_ok) - CNT_W'(inst_data_ok);
      if (rvalid && rready && (count == '0 || !rlast)) proto_err <= 1'b1;
    end
  end
  a_no_proto_err: assert property (@(posedge clk) disable iff (!resetn) !proto_err);
endmodule
